// File: rtl/delivery_game_core.sv
// Delivery game engine: N-lane scrolling obstacle/objective map with lives, score,
// pause and a programmable scroll period; columns arrive through a one-cycle ack handshake.
module delivery_game_core #(
  parameter  int LANES     = 4,
  parameter  int DEPTH     = 8,
  parameter  int SCORE_W   = 4,
  parameter  int LIVES     = 3,
  parameter  int WIN_SCORE = 15,
  parameter  int PER_W     = 16,
  localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   jogar_i,
  input  logic                   pausa_i,
  input  logic [LANES-1:0]       botoes_i,
  input  logic [PER_W-1:0]       periodo_i,
  input  logic                   periodo_valid_i,
  input  logic [LANES-1:0]       col_obstacle_i,
  input  logic [LANES-1:0]       col_objective_i,
  output logic                   col_ack_o,
  output logic [2:0]             estado_o,
  output logic [SCORE_W-1:0]     pontuacao_o,
  output logic [2:0]             vidas_o,
  output logic                   pronto_o,
  output logic [LANE_W-1:0]      player_lane_o,
  output logic [LANES*DEPTH-1:0] db_map_obstacle_o,
  output logic [LANES*DEPTH-1:0] db_map_objective_o
);

  // state     | meaning
  // IDLE      | waiting for jogar
  // PREP      | one cycle: clear map, reload lives/score/lane/counter
  // PLAY      | scrolling, moving, collision checks
  // PAUSE     | everything frozen until next pausa edge
  // WIN       | score reached WIN_SCORE, outputs held
  // GAME_OVER | lives exhausted, outputs held
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PREP      = 3'd1,
    S_PLAY      = 3'd2,
    S_PAUSE     = 3'd3,
    S_WIN       = 3'd4,
    S_GAME_OVER = 3'd5
  } state_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_t                   state_q, state_d;
  logic [LANES*DEPTH-1:0]   obs_q, obs_d;
  logic [LANES*DEPTH-1:0]   obj_q, obj_d;
  logic [SCORE_W-1:0]       score_q, score_d;
  logic [2:0]               lives_q, lives_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic [PER_W-1:0]         period_q, period_d;
  logic [PER_W-1:0]         cnt_q, cnt_d;
  logic [LANES-1:0]         btn_prev_q;
  logic                     pausa_prev_q;

  logic                     tick;
  logic                     pausa_rise;
  logic [LANES-1:0]         btn_rise;
  logic                     hit_obs;
  logic                     hit_obj;

  assign pausa_rise = pausa_i & ~pausa_prev_q;
  assign btn_rise   = botoes_i & ~btn_prev_q;
  // Counter only advances in PLAY; a shrunken period lets it run on and wrap.
  assign tick       = (state_q == S_PLAY) && (cnt_q == (period_q - PER_W'(1)));

  always_comb begin
    state_d  = state_q;
    obs_d    = obs_q;
    obj_d    = obj_q;
    score_d  = score_q;
    lives_d  = lives_q;
    lane_d   = lane_q;
    cnt_d    = cnt_q;
    hit_obs  = 1'b0;
    hit_obj  = 1'b0;
    period_d = period_q;

    if (periodo_valid_i) begin
      period_d = (periodo_i == '0) ? PER_W'(1) : periodo_i;
    end

    case (state_q)
      S_IDLE: begin
        if (jogar_i) state_d = S_PREP;
      end

      S_PREP: begin
        obs_d   = '0;
        obj_d   = '0;
        score_d = '0;
        lives_d = 3'(LIVES);
        lane_d  = '0;
        cnt_d   = '0;
        state_d = S_PLAY;
      end

      S_PLAY: begin
        if (tick) begin
          cnt_d = '0;
          for (int l = 0; l < LANES; l++) begin
            obs_d[l*DEPTH +: DEPTH] = {col_obstacle_i[l],  obs_q[l*DEPTH+1 +: DEPTH-1]};
            obj_d[l*DEPTH +: DEPTH] = {col_objective_i[l], obj_q[l*DEPTH+1 +: DEPTH-1]};
          end
        end else begin
          cnt_d = cnt_q + PER_W'(1);
        end

        // Descending scan so the lowest-index rising button has the final say.
        for (int l = LANES - 1; l >= 0; l--) begin
          if (btn_rise[l]) lane_d = LANE_W'(l);
        end

        for (int l = 0; l < LANES; l++) begin
          if (lane_d == LANE_W'(l)) begin
            hit_obs = obs_d[l*DEPTH];
            hit_obj = obj_d[l*DEPTH];
            if (obs_d[l*DEPTH] || obj_d[l*DEPTH]) begin
              obs_d[l*DEPTH] = 1'b0;
              obj_d[l*DEPTH] = 1'b0;
            end
          end
        end

        if (hit_obs) begin
          lives_d = (lives_q != 3'd0) ? (lives_q - 3'd1) : 3'd0;
        end else if (hit_obj) begin
          score_d = (score_q == SCORE_MAX) ? score_q : (score_q + SCORE_W'(1));
        end

        if (lives_d == 3'd0) begin
          state_d = S_GAME_OVER;
        end else if (score_d == SCORE_W'(WIN_SCORE)) begin
          state_d = S_WIN;
        end else if (pausa_rise) begin
          state_d = S_PAUSE;
        end
      end

      S_PAUSE: begin
        if (pausa_rise) state_d = S_PLAY;
      end

      S_WIN, S_GAME_OVER: begin
        if (jogar_i) state_d = S_PREP;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= S_IDLE;
      obs_q        <= '0;
      obj_q        <= '0;
      score_q      <= '0;
      lives_q      <= 3'(LIVES);
      lane_q       <= '0;
      period_q     <= PER_W'(1);
      cnt_q        <= '0;
      btn_prev_q   <= '0;
      pausa_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      obs_q        <= obs_d;
      obj_q        <= obj_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      lane_q       <= lane_d;
      period_q     <= period_d;
      cnt_q        <= cnt_d;
      btn_prev_q   <= botoes_i;
      pausa_prev_q <= pausa_i;
    end
  end

  assign col_ack_o          = tick;
  assign estado_o           = state_q;
  assign pontuacao_o        = score_q;
  assign vidas_o            = lives_q;
  assign pronto_o           = (state_q == S_WIN) || (state_q == S_GAME_OVER);
  assign player_lane_o      = lane_q;
  assign db_map_obstacle_o  = obs_q;
  assign db_map_objective_o = obj_q;

endmodule

// File: tb/tb_delivery_game_core.sv
// Directed bench for delivery_game_core: scrolling, collisions, win/lose, pause,
// period programming and asynchronous reset, all against hand-computed values.
module tb_delivery_game_core;

  logic        clk;
  logic        rst_n;
  logic        jogar;
  logic        pausa;
  logic [3:0]  botoes;
  logic [15:0] periodo;
  logic        periodo_valid;
  logic [3:0]  col_obs;
  logic [3:0]  col_obj;
  logic        col_ack;
  logic [2:0]  estado;
  logic [3:0]  pont;
  logic [2:0]  vidas;
  logic        pronto;
  logic [1:0]  lane;
  logic [31:0] map_obs;
  logic [31:0] map_obj;

  int checks = 0;
  int errors = 0;

  delivery_game_core dut (
    .clock_i            (clk),
    .reset_i            (rst_n),
    .jogar_i            (jogar),
    .pausa_i            (pausa),
    .botoes_i           (botoes),
    .periodo_i          (periodo),
    .periodo_valid_i    (periodo_valid),
    .col_obstacle_i     (col_obs),
    .col_objective_i    (col_obj),
    .col_ack_o          (col_ack),
    .estado_o           (estado),
    .pontuacao_o        (pont),
    .vidas_o            (vidas),
    .pronto_o           (pronto),
    .player_lane_o      (lane),
    .db_map_obstacle_o  (map_obs),
    .db_map_objective_o (map_obj)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; jogar = 1'b0; pausa = 1'b0; botoes = 4'b0;
    periodo = 16'd0; periodo_valid = 1'b0; col_obs = 4'b0; col_obj = 4'b0;

    cyc(2);
    chk("rst_estado", 64'(estado), 64'd0);
    chk("rst_vidas", 64'(vidas), 64'd3);
    chk("rst_score", 64'(pont), 64'd0);
    chk("rst_ack", 64'(col_ack), 64'd0);
    chk("rst_lane", 64'(lane), 64'd0);
    chk("rst_map", 64'({map_obs, map_obj}), 64'd0);
    rst_n = 1'b1;
    cyc(1);
    chk("idle_hold", 64'(estado), 64'd0);

    // Period 4, constant obstacle in lane 0 with player on lane 0
    periodo = 16'd4; periodo_valid = 1'b1; jogar = 1'b1; col_obs = 4'b0001;
    cyc(1);
    chk("a_prep", 64'(estado), 64'd1);
    periodo_valid = 1'b0; jogar = 1'b0;
    cyc(1);
    chk("a_play", 64'(estado), 64'd2);
    chk("a_ack_c0", 64'(col_ack), 64'd0);
    cyc(2);
    chk("a_ack_c2", 64'(col_ack), 64'd0);
    cyc(1);
    chk("a_ack_c3", 64'(col_ack), 64'd1);
    cyc(1);
    chk("a_ack_after", 64'(col_ack), 64'd0);
    chk("a_first_col", 64'(map_obs), 64'h80);
    cyc(24);
    chk("a_tick7_map", 64'(map_obs), 64'hFE);
    chk("a_tick7_vidas", 64'(vidas), 64'd3);
    cyc(4);
    chk("a_hit_vidas", 64'(vidas), 64'd2);
    chk("a_hit_cleared", 64'(map_obs), 64'hFE);
    col_obs = 4'b0000;

    // Pause with counter at 1 -> frozen at 2
    cyc(1);
    pausa = 1'b1;
    cyc(1);
    chk("p_enter", 64'(estado), 64'd3);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("p_no_ack", 64'(col_ack), 64'd0);
    end
    chk("p_map_frozen", 64'(map_obs), 64'hFE);
    chk("p_vidas", 64'(vidas), 64'd2);
    pausa = 1'b0;
    cyc(1);
    chk("p_still", 64'(estado), 64'd3);
    pausa = 1'b1;
    cyc(1);
    chk("p_resume", 64'(estado), 64'd2);
    chk("p_resume_ack", 64'(col_ack), 64'd0);
    botoes = 4'b0100;
    cyc(1);
    chk("p_lane2", 64'(lane), 64'd2);
    chk("p_counter_cont", 64'(col_ack), 64'd1);

    // Period 0 is stored as 1: a tick on every cycle afterwards
    periodo = 16'd0; periodo_valid = 1'b1;
    cyc(1);
    periodo_valid = 1'b0;
    chk("z_shift", 64'(map_obs), 64'h7F);
    chk("z_vidas", 64'(vidas), 64'd2);
    for (int i = 0; i < 3; i++) begin
      chk("z_ack_every", 64'(col_ack), 64'd1);
      cyc(1);
    end

    rst_n = 1'b0; pausa = 1'b0; botoes = 4'b0;
    cyc(1);
    rst_n = 1'b1;

    // Objectives on lane 1, period 1, play until WIN
    col_obs = 4'b0000; col_obj = 4'b0010; jogar = 1'b1;
    cyc(1);
    chk("b_prep", 64'(estado), 64'd1);
    jogar = 1'b0;
    cyc(1);
    chk("b_play", 64'(estado), 64'd2);
    botoes = 4'b1010;
    cyc(1);
    chk("b_lane_lowest", 64'(lane), 64'd1);
    botoes = 4'b1000;
    cyc(1);
    chk("b_lane_held", 64'(lane), 64'd1);
    cyc(5);
    chk("b_score0", 64'(pont), 64'd0);
    cyc(1);
    chk("b_score1", 64'(pont), 64'd1);
    cyc(1);
    chk("b_score2", 64'(pont), 64'd2);
    cyc(12);
    chk("b_score14", 64'(pont), 64'd14);
    chk("b_not_won", 64'(pronto), 64'd0);
    cyc(1);
    chk("b_score15", 64'(pont), 64'd15);
    chk("b_win", 64'(estado), 64'd4);
    chk("b_pronto", 64'(pronto), 64'd1);
    chk("b_objmap", 64'(map_obj), 64'hFE00);
    chk("b_obsmap", 64'(map_obs), 64'h0);
    cyc(5);
    chk("b_frozen_map", 64'(map_obj), 64'hFE00);
    chk("b_frozen_score", 64'(pont), 64'd15);
    chk("b_frozen_ack", 64'(col_ack), 64'd0);
    chk("b_frozen_state", 64'(estado), 64'd4);

    // Obstacle and objective together on lane 1
    botoes = 4'b0000; col_obs = 4'b0010; col_obj = 4'b0010; jogar = 1'b1;
    cyc(1);
    chk("c_prep", 64'(estado), 64'd1);
    jogar = 1'b0;
    cyc(1);
    chk("c_play", 64'(estado), 64'd2);
    chk("c_score_reset", 64'(pont), 64'd0);
    botoes = 4'b0010;
    cyc(1);
    chk("c_lane1", 64'(lane), 64'd1);
    cyc(6);
    chk("c_vidas3", 64'(vidas), 64'd3);
    cyc(1);
    chk("c_vidas2", 64'(vidas), 64'd2);
    chk("c_score_kept", 64'(pont), 64'd0);
    chk("c_obs_clear", 64'(map_obs), 64'hFE00);
    chk("c_obj_clear", 64'(map_obj), 64'hFE00);
    cyc(1);
    chk("c_vidas1", 64'(vidas), 64'd1);
    cyc(1);
    chk("c_vidas0", 64'(vidas), 64'd0);
    chk("c_gameover", 64'(estado), 64'd5);
    chk("c_pronto", 64'(pronto), 64'd1);
    jogar = 1'b1;
    cyc(1);
    chk("c_restart_prep", 64'(estado), 64'd1);
    jogar = 1'b0; col_obs = 4'b0; col_obj = 4'b0; botoes = 4'b0;
    cyc(1);
    chk("c_restart_play", 64'(estado), 64'd2);
    chk("c_restart_vidas", 64'(vidas), 64'd3);
    chk("c_restart_score", 64'(pont), 64'd0);
    chk("c_restart_map", 64'({map_obs, map_obj}), 64'd0);
    chk("c_restart_lane", 64'(lane), 64'd0);

    // Build score 3 / vidas 1 on lane 0, then reset asynchronously mid-cycle
    col_obj = 4'b0001;
    cyc(3);
    col_obj = 4'b0000; col_obs = 4'b0001;
    cyc(2);
    col_obs = 4'b0000;
    cyc(7);
    chk("d_score3", 64'(pont), 64'd3);
    chk("d_vidas1", 64'(vidas), 64'd1);
    chk("d_playing", 64'(estado), 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("d_async_estado", 64'(estado), 64'd0);
    chk("d_async_score", 64'(pont), 64'd0);
    chk("d_async_vidas", 64'(vidas), 64'd3);
    chk("d_async_map", 64'({map_obs, map_obj}), 64'd0);
    chk("d_async_ack", 64'(col_ack), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
